// File: rtl/iterative_mdu_if.sv
// rtl/iterative_mdu_if.sv - start/op/operand request and HI/LO read-back bundle for iterative_mdu
interface iterative_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cancel;
    logic             read_sel;
    logic             busy;
    logic [WIDTH-1:0] data_read;
    logic             div_zero;

    modport master (
        output start, op, operand1, operand2, cancel, read_sel,
        input  busy, data_read, div_zero
    );

    modport slave (
        input  start, op, operand1, operand2, cancel, read_sel,
        output busy, data_read, div_zero
    );
endinterface

// File: rtl/iterative_mdu.sv
// rtl/iterative_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
// Multiplies complete after MUL_CYCLES; divides run WIDTH restoring steps plus a sign-fix cycle.
module iterative_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic           clock,
    input  logic           reset,
    iterative_mdu_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, acc;
    logic [WIDTH:0]     shifted, diff;

    assign bus.busy      = (state_q != IDLE);
    assign bus.data_read = bus.read_sel ? hi_q : lo_q;
    assign bus.div_zero  = div_zero_q;

    // Divider works on magnitudes; sign flags are captured at acceptance.
    always_comb begin
        a_neg   = (bus.op == OP_DIV) && bus.operand1[WIDTH-1];
        b_neg   = (bus.op == OP_DIV) && bus.operand2[WIDTH-1];
        a_mag   = a_neg ? -bus.operand1 : bus.operand1;
        b_mag   = b_neg ? -bus.operand2 : bus.operand2;
        ext_a   = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b   = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        product = ext_a * ext_b;
        acc     = {hi_q, lo_q};
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        count_d    = count_q;
        op_d       = op_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = MUL;
                            count_d = CW'(MUL_CYCLES - 1);
                            op_d    = bus.op[2:0];
                            a_d     = bus.operand1;
                            b_d     = bus.operand2;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            count_d = CW'(WIDTH);
                            a_d     = bus.operand1;
                            b_d     = b_mag;
                            quo_d   = a_mag;
                            rem_d   = '0;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                        end
                        OP_MTHI: hi_d = bus.operand1;
                        OP_MTLO: lo_d = bus.operand1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = IDLE;
                    case (op_q[2:1])
                        2'b10:   {hi_d, lo_d} = acc + product;
                        2'b11:   {hi_d, lo_d} = acc - product;
                        default: {hi_d, lo_d} = product;
                    endcase
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DIV: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Sign-fix cycle; most-negative / -1 wraps back to most-negative naturally.
                    state_d = IDLE;
                    if (b_q == '0) begin
                        lo_d       = '1;
                        hi_d       = a_q;
                        div_zero_d = 1'b1;
                    end else begin
                        lo_d       = q_neg_q ? -quo_q : quo_q;
                        hi_d       = r_neg_q ? -rem_q : rem_q;
                        div_zero_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            count_q    <= '0;
            op_q       <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            count_q    <= count_d;
            op_q       <= op_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
        end
    end
endmodule

// File: doc/iterative_mdu.md
ITERATIVE_MDU -- requirements
Module: iterative_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width in bits (even, >= 8).
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy cycles for any multiply-class op (>= 1).
REQ-003 SHALL have ports clock and reset (reset: synchronous, active-high; clock: clock) listed first.
REQ-004 SHALL have port start  in  1  request to launch op on this cycle.
REQ-005 SHALL have port op  in  4  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 no-op.
REQ-006 SHALL have ports operand1, operand2  in  WIDTH  rs/rt values.
REQ-007 SHALL have port cancel  in  1  flush; aborts in-flight op.
REQ-008 SHALL have port read_sel  in  1  0 selects LO, 1 selects HI on data_read.
REQ-009 SHALL have port busy  out  1  op in flight; EX stage stalls on it.
REQ-010 SHALL have port data_read  out  WIDTH  selected HI/LO, combinational from registers.
REQ-011 SHALL have port div_zero  out  1  registered sticky-for-one-op flag: last completed divide had operand2 == 0.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV; busy = (state != IDLE), combinational from state.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored with no state effect.
REQ-014 SHALL, on accepted multiply-class op at edge T, enter MUL with busy high exactly MUL_CYCLES cycles; HI/LO update on the edge where busy falls.
REQ-015 SHALL, on accepted DIV/DIVU at edge T, enter DIV with busy high exactly WIDTH+1 cycles (WIDTH restoring iterations, one sign-fix cycle); HI/LO update on the edge where busy falls.
REQ-016 SHALL latch operands at acceptance; later operand changes SHALL NOT affect the result.
REQ-017 SHALL, for MTHI/MTLO in IDLE, write operand1 to HI/LO on the next edge, busy stays low.
REQ-018 SHALL treat op codes 10-15 with start as no-op: no state change, busy low.
REQ-019 SHALL compute MULT/MULTU as 2*WIDTH product, {HI,LO} = product, signed/unsigned per op.
REQ-020 SHALL compute MADD(U) as {HI,LO} += product and MSUB(U) as {HI,LO} -= product, modulo 2^(2*WIDTH), using {HI,LO} at completion.
REQ-021 SHALL compute DIV with quotient truncated toward zero into LO, remainder into HI with sign of dividend.
REQ-022 SHALL, for DIV with operand1 = most-negative and operand2 = -1, give LO = most-negative, HI = 0.
REQ-023 SHALL, for divide by zero, give LO = all ones, HI = operand1, and set div_zero to 1; any other completed divide clears div_zero.
REQ-024 SHALL, on cancel in MUL or DIV, return to IDLE next edge with HI, LO, div_zero unchanged.
REQ-025 SHALL give cancel priority over start in the same cycle; the start is dropped.
REQ-026 SHALL, when busy falls, accept a new start in the very next cycle (back-to-back, no dead cycle).
REQ-027 SHALL allow data_read to show pre-op HI/LO during busy; consumers stall on busy.

Reset
REQ-028 SHALL, on reset, set state IDLE, busy 0, HI 0, LO 0, div_zero 0, iteration counter 0, data_read 0.
REQ-029 SHALL give reset priority over cancel and start; reset mid-operation discards the op.

Verification
REQ-030 WIDTH=32: MULT 0xFFFFFFFF x 0x00000002 -> busy 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 DIV -7 / 2 -> busy 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, div_zero=1.
REQ-032 MTHI 0, MTLO 10, then MADD 3x4 -> HI=0, LO=22; then MSUBU 5x5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIV started, cancel at busy cycle 10 -> busy 0 next cycle, HI/LO unchanged; start+cancel same cycle -> busy stays 0.
REQ-034 start asserted during busy with MTLO 0x55 -> ignored, LO keeps product; reset at busy cycle 3 -> all outputs 0 next cycle.
REQ-035 WIDTH=16, MUL_CYCLES=1: DIV 0x8000 / 0xFFFF -> busy 17 cycles, LO=0x8000, HI=0; back-to-back MULT accepted the cycle after busy falls.
